// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bufz_arb.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__bufz_arb.sv - round-robin arbitrated multi-channel tristate bus driver
module gf180mcu_fd_sc_mcu7t5v0__bufz_arb #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int TURN  = 1
) (
`ifdef USE_POWER_PINS
  inout  wire                    VDD,
  inout  wire                    VSS,
`endif
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NCH-1:0]         REQ,
  input  logic [NCH*WIDTH-1:0]   I,
  output logic [NCH-1:0]         GNT,
  output logic [WIDTH-1:0]       Z,
  output logic                   OE,
  output logic                   BUSY
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  state_t           state, state_n;
  logic [PW-1:0]    owner, owner_n;
  logic [PW-1:0]    ptr, ptr_n;
  logic [WIDTH-1:0] dreg, dreg_n;
  logic [2:0]       cnt, cnt_n;

  logic [PW-1:0]    win;
  logic             found;
  int               idx;
  logic             do_arb;

  // Round-robin search starting just after the last winner, so the previous owner ranks last
  always_comb begin
    win   = ptr;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(ptr) + k) % NCH;
      if (!found && REQ[idx]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  // Next-state logic: hold the owner while it requests, insert TURN high-Z cycles on release
  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    dreg_n  = dreg;
    cnt_n   = cnt;
    do_arb  = 1'b0;
    case (state)
      IDLE: begin
        if (|REQ) do_arb = 1'b1;
      end
      DRIVE: begin
        if (REQ[owner]) begin
          dreg_n = I[int'(owner)*WIDTH +: WIDTH];
        end else if (TURN > 0) begin
          state_n = GAP;
          cnt_n   = 3'(TURN - 1);
        end else if (|REQ) begin
          do_arb = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      GAP: begin
        if (cnt != 3'd0) cnt_n = cnt - 3'd1;
        else if (|REQ) do_arb = 1'b1;
        else state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // A new owner's data is captured on the granting edge so it drives immediately after it
    if (do_arb) begin
      state_n = DRIVE;
      owner_n = win;
      ptr_n   = win;
      dreg_n  = I[int'(win)*WIDTH +: WIDTH];
    end
  end

  // State registers; reset points ptr at the last channel so channel 0 wins first
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= PW'(NCH - 1);
      dreg  <= '0;
      cnt   <= 3'd0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      ptr   <= ptr_n;
      dreg  <= dreg_n;
      cnt   <= cnt_n;
    end
  end

  // Outputs decode purely from registers, so the bus is only ever driven by one owner
  assign OE   = (state == DRIVE);
  assign BUSY = (state != IDLE);
  assign GNT  = OE ? (NCH'(1) << owner) : '0;
  assign Z    = OE ? dreg : {WIDTH{1'bz}};

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__bufz_arb.sv
// tb/tb_gf180mcu_fd_sc_mcu7t5v0__bufz_arb.sv - directed bench for the arbitrated tristate bus driver
module tb_gf180mcu_fd_sc_mcu7t5v0__bufz_arb;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] i;
    logic [3:0]  gnt;
    logic        oe;
    logic        busy;
    logic [7:0]  z;
  } vec_t;

  localparam logic [31:0] BASE = 32'hD3C2B1A0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [3:0]  req_a, req_b;
  logic [31:0] i_a, i_b;
  logic [3:0]  gnt_a, gnt_b;
  wire  [7:0]  z_a, z_b;
  logic        oe_a, oe_b, busy_a, busy_b;

  int checks = 0;
  int errors = 0;
  logic inv_en = 1'b0;
  vec_t vq[$];

  gf180mcu_fd_sc_mcu7t5v0__bufz_arb #(.WIDTH(8), .NCH(4), .TURN(2)) dut_a (
    .CLK(clk), .RST(rst_a), .REQ(req_a), .I(i_a),
    .GNT(gnt_a), .Z(z_a), .OE(oe_a), .BUSY(busy_a)
  );

  gf180mcu_fd_sc_mcu7t5v0__bufz_arb #(.WIDTH(8), .NCH(4), .TURN(0)) dut_b (
    .CLK(clk), .RST(rst_b), .REQ(req_b), .I(i_b),
    .GNT(gnt_b), .Z(z_b), .OE(oe_b), .BUSY(busy_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic [31:0] iv,
                     input logic [3:0] g, input logic o, input logic b, input logic [7:0] zv);
    vec_t v;
    v.rst = r; v.req = rq; v.i = iv; v.gnt = g; v.oe = o; v.busy = b; v.z = zv;
    vq.push_back(v);
  endtask

  task automatic step_b(input logic r, input logic [3:0] rq);
    rst_b = r;
    req_b = rq;
    @(posedge clk);
    #1;
  endtask

  // One-owner and OE/GNT consistency on both instances, sampled mid-cycle
  always @(negedge clk) begin
    if (inv_en) begin
      chk("inv_a", {31'd0, ($countones(gnt_a) <= 1) && (oe_a == (gnt_a != 4'd0))}, 32'd1);
      chk("inv_b", {31'd0, ($countones(gnt_b) <= 1) && (oe_b == (gnt_b != 4'd0))}, 32'd1);
    end
  end

  initial begin
    rst_a = 1'b1; req_a = 4'h0; i_a = BASE;
    rst_b = 1'b1; req_b = 4'h0; i_b = 32'h0;

    // TURN=2 instance: rst, req, I, expected gnt, oe, busy, z (z checked only when oe=1)
    add(1, 4'hF, BASE,         4'h0, 0, 0, 8'h00);
    add(1, 4'hF, BASE,         4'h0, 0, 0, 8'h00);
    add(0, 4'hF, BASE,         4'h1, 1, 1, 8'hA0);
    add(0, 4'h1, 32'hD3C2B1A7, 4'h1, 1, 1, 8'hA7);
    add(0, 4'h2, BASE,         4'h0, 0, 1, 8'h00);
    add(0, 4'h2, BASE,         4'h0, 0, 1, 8'h00);
    add(0, 4'h2, BASE,         4'h2, 1, 1, 8'hB1);
    add(0, 4'h0, BASE,         4'h0, 0, 1, 8'h00);
    add(0, 4'h0, BASE,         4'h0, 0, 1, 8'h00);
    add(0, 4'h0, BASE,         4'h0, 0, 0, 8'h00);
    add(0, 4'h4, 32'hD310B1A0, 4'h4, 1, 1, 8'h10);
    add(0, 4'h5, 32'hD311B1A0, 4'h4, 1, 1, 8'h11);
    add(0, 4'h5, 32'hD312B1A0, 4'h4, 1, 1, 8'h12);
    add(0, 4'h8, BASE,         4'h0, 0, 1, 8'h00);
    add(0, 4'h8, BASE,         4'h0, 0, 1, 8'h00);
    add(0, 4'h8, BASE,         4'h8, 1, 1, 8'hD3);
    add(1, 4'h8, BASE,         4'h0, 0, 0, 8'h00);
    add(0, 4'h9, BASE,         4'h1, 1, 1, 8'hA0);

    for (int n = 0; n < vq.size(); n++) begin
      rst_a = vq[n].rst;
      req_a = vq[n].req;
      i_a   = vq[n].i;
      @(posedge clk);
      #1;
      inv_en = 1'b1;
      chk($sformatf("row%0d_gnt", n), {28'd0, gnt_a}, {28'd0, vq[n].gnt});
      chk($sformatf("row%0d_oe", n), {31'd0, oe_a}, {31'd0, vq[n].oe});
      chk($sformatf("row%0d_busy", n), {31'd0, busy_a}, {31'd0, vq[n].busy});
      if (vq[n].oe) chk($sformatf("row%0d_z", n), {24'd0, z_a}, {24'd0, vq[n].z});
    end

    // TURN=0 instance: back-to-back handover without a high-Z cycle
    i_b = 32'h00005AA5;
    step_b(1, 4'h0);
    chk("b_rst_gnt", {28'd0, gnt_b}, 32'd0);
    chk("b_rst_busy", {31'd0, busy_b}, 32'd0);
    step_b(0, 4'h3);
    chk("b_ho0_gnt", {28'd0, gnt_b}, 32'h1);
    chk("b_ho0_z", {24'd0, z_b}, 32'hA5);
    step_b(0, 4'h2);
    chk("b_ho1_gnt", {28'd0, gnt_b}, 32'h2);
    chk("b_ho1_oe", {31'd0, oe_b}, 32'd1);
    chk("b_ho1_z", {24'd0, z_b}, 32'h5A);
    step_b(0, 4'h0);
    chk("b_rel_oe", {31'd0, oe_b}, 32'd0);
    chk("b_rel_busy", {31'd0, busy_b}, 32'd0);

    // Round robin: each owner drops for one edge while everyone else keeps requesting
    i_b = 32'h44332211;
    step_b(1, 4'h0);
    step_b(0, 4'hF);
    chk("rr0_gnt", {28'd0, gnt_b}, 32'h1);
    for (int j = 1; j <= 4; j++) begin
      step_b(0, ~(4'h1 << ((j - 1) % 4)));
      chk($sformatf("rr%0d_gnt", j), {28'd0, gnt_b}, 32'h1 << (j % 4));
      chk($sformatf("rr%0d_z", j), {24'd0, z_b}, 32'h11 * ((j % 4) + 1));
    end

    inv_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__bufz_arb.md
# gf180mcu_fd_sc_mcu7t5v0__bufz_arb

Parametrised, clocked multi-channel tristate bus driver: NCH requesters share one WIDTH-bit tristate bus Z, with round-robin arbitration, registered output data and a programmable number of guaranteed high-Z turnaround cycles between owners. It replaces hand-placed banks of single-bit tristate buffers plus glue logic wherever several sources drive a shared on-chip bus, and removes driver overlap (contention) by construction.

## Interface
- WIDTH, 8, bus width in bits (1..64)
- NCH, 4, number of requesting channels (2..16)
- TURN, 1, high-Z turnaround cycles inserted between consecutive owners (0..7)
- CLK  input  1  rising-edge clock; all state changes on this edge
- RST  input  1  reset, synchronous, active-high
- REQ  input  NCH  per-channel bus request, level-sensitive
- I  input  NCH*WIDTH  channel data; channel c occupies bits [c*WIDTH +: WIDTH]
- GNT  output  NCH  one-hot grant (all-zero when no owner), registered
- Z  output  WIDTH  shared tristate bus; driven only while OE=1, else all bits high-Z
- OE  output  1  bus-driven indicator, registered
- BUSY  output  1  state != IDLE
- VDD, VSS  inout  1  power pins, present only under USE_POWER_PINS

## Operation
- One clock (CLK); reset is synchronous and active-high (RST).
- Registers: state {IDLE, DRIVE, GAP}, owner index, round-robin pointer ptr, data register dreg[WIDTH], gap counter cnt[3].
- Z = OE ? dreg : all-Z. OE = (state==DRIVE). GNT = onehot(owner) in DRIVE, else 0.
- Arbitration (ARB): winner = first c with REQ[c]=1 searching ptr+1, ptr+2, ... mod NCH. On grant: state<=DRIVE, owner<=winner, ptr<=winner, dreg<=I[winner].
- IDLE: REQ!=0 -> ARB; else stay.
- DRIVE, REQ[owner]=1: stay; dreg<=I[owner] every cycle (other channels' requests ignored; no preemption).
- DRIVE, REQ[owner]=0: if TURN>0 -> state<=GAP, cnt<=TURN-1; else if REQ!=0 -> ARB directly (back-to-back handover, no Z cycle); else -> IDLE.
- GAP: if cnt!=0 -> cnt<=cnt-1; else if REQ!=0 -> ARB; else -> IDLE.
- Reset values: state IDLE, GNT 0, OE 0, BUSY 0, Z all high-Z, dreg 0, owner 0, cnt 0, ptr NCH-1 (channel 0 wins first contest).

## Timing
- Grant latency: REQ sampled high at edge k (bus IDLE) -> GNT, OE=1, Z=I[winner] as sampled at edge k, valid after edge k.
- Data latency while driving: exactly 1 cycle (Z after edge k = I[owner] sampled at edge k).
- Release: owner REQ sampled low at edge k -> OE=0, GNT=0, Z high-Z after edge k (TURN>0 or no other requester).
- Turnaround: with a requester pending, Z is high-Z for exactly TURN cycles between owners; new owner drives after edge k+TURN.
- TURN=0: handover at a single edge; Z never high-Z, GNT switches one-hot to one-hot, never two bits set.
- Simultaneous requests: round-robin only; a channel releasing and re-requesting competes behind all others.
- RST high at any edge (including mid-DRIVE or mid-GAP) overrides all other transitions; Z high-Z after that edge. RST has no asynchronous effect.
- Invariants: popcount(GNT)<=1 every cycle; OE=1 iff GNT!=0.

## Test plan
- Reset: drive RST=1 for 2 cycles with REQ=4'b1111 -> GNT=0, OE=0, Z=8'hzz, BUSY=0; release RST -> GNT=4'b0001 after next edge, Z=I[0].
- Single owner streaming: REQ[2]=1, I[2] stepping 8'h10,8'h11,8'h12 -> GNT=4'b0100, Z follows with 1-cycle lag, no other channel granted while REQ[2] held.
- Turnaround TURN=2: channel 0 drops REQ with REQ[1]=1 -> Z high-Z for exactly 2 cycles, then GNT=4'b0010, Z=I[1].
- TURN=0 handover: REQ=4'b0011, channel 0 drops -> GNT 4'b0001 -> 4'b0010 at one edge, OE stays 1, Z changes 8'hA5 -> 8'h5A with no high-Z cycle.
- Round-robin fairness: REQ=4'b1111, each owner holds 1 cycle then drops and re-raises -> grant order 0,1,2,3,0; popcount(GNT)<=1 asserted throughout.
- Reset mid-drive: RST=1 during DRIVE with owner 3 -> after that edge OE=0, Z high-Z, ptr=3 reset to NCH-1 so channel 0 wins next.
